// File: rtl/fetch_ctrl.sv
// fetch_ctrl: RV32I fetch sequencer.
// Owns the PC, issues imem reads, buffers two words for decode.
module fetch_ctrl #(
  parameter int              PC_W     = 11,
  parameter int              DATA_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_en,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              halt_i,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [PC_W-1:0]   if_pc,
  output logic              halted_o
);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_e;

  localparam logic [PC_W-1:0] STEP = PC_W'(4);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] hi_q, hi_d, ti_q, ti_d;
  logic [PC_W-1:0]   hp_q, hp_d, tp_q, tp_d;
  logic              inf_q, inf_d;
  logic [PC_W-1:0]   inf_pc_q, inf_pc_d;
  logic              inf_ep_q, inf_ep_d;
  logic              ep_q, ep_d;

  logic [PC_W-1:0]   tgt;
  logic              resp_ok;
  logic              push;
  logic              pop;
  logic              issue;
  logic [2:0]        need;
  logic              rp_unused;

  // Low address bits of a redirect never matter: fetch is word aligned.
  assign tgt       = {redirect_pc[PC_W-1:2], 2'b00};
  assign rp_unused = ^redirect_pc[1:0];

  // A response is kept only if its epoch survived every redirect since issue.
  assign resp_ok = inf_q && (inf_ep_q == ep_q);
  assign push    = resp_ok && !redirect_valid;
  assign need    = {1'b0, occ_q} + {2'b00, resp_ok};

  // State register and all datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      occ_q    <= 2'd0;
      hi_q     <= '0;
      hp_q     <= '0;
      ti_q     <= '0;
      tp_q     <= '0;
      inf_q    <= 1'b0;
      inf_pc_q <= '0;
      inf_ep_q <= 1'b0;
      ep_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      occ_q    <= occ_d;
      hi_q     <= hi_d;
      hp_q     <= hp_d;
      ti_q     <= ti_d;
      tp_q     <= tp_d;
      inf_q    <= inf_d;
      inf_pc_q <= inf_pc_d;
      inf_ep_q <= inf_ep_d;
      ep_q     <= ep_d;
    end
  end

  // Run/drain/halt sequencing; drain waits for the last response.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (halt_i) state_d = DRAIN;
      DRAIN: begin
        if (!halt_i)     state_d = RUN;
        else if (!inf_q) state_d = HALT;
      end
      HALT:    if (!halt_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Outputs: handshake, issue decision and read strobe.
  always_comb begin
    if_valid  = !rst && (occ_q != 2'd0) && !redirect_valid;
    pop       = if_valid && if_ready;
    issue     = !rst && (state_q == RUN) && !halt_i &&
                (redirect_valid || (need < (3'd2 + {2'b00, pop})));
    imem_en   = issue;
    imem_addr = '0;
    if (issue) imem_addr = redirect_valid ? tgt : pc_q;
    if_instr  = '0;
    if_pc     = '0;
    if (!rst && (occ_q != 2'd0)) begin
      if_instr = hi_q;
      if_pc    = hp_q;
    end
    halted_o  = !rst && (state_q == HALT);
  end

  // PC, epoch, in-flight tracking and the 2-entry queue.
  always_comb begin
    pc_d     = pc_q;
    ep_d     = ep_q;
    occ_d    = occ_q;
    hi_d     = hi_q;
    hp_d     = hp_q;
    ti_d     = ti_q;
    tp_d     = tp_q;
    if (redirect_valid) begin
      ep_d = ~ep_q;
      pc_d = issue ? tgt + STEP : tgt;
    end else if (issue) begin
      pc_d = pc_q + STEP;
    end
    inf_d    = issue;
    inf_pc_d = imem_addr;
    inf_ep_d = ep_d;
    if (redirect_valid) begin
      occ_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b01: begin
          hi_d  = ti_q;
          hp_d  = tp_q;
          occ_d = occ_q - 2'd1;
        end
        2'b10: begin
          if (occ_q == 2'd0) begin
            hi_d = imem_rdata;
            hp_d = inf_pc_q;
          end else begin
            ti_d = imem_rdata;
            tp_d = inf_pc_q;
          end
          occ_d = occ_q + 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            hi_d = imem_rdata;
            hp_d = inf_pc_q;
          end else begin
            hi_d = ti_q;
            hp_d = tp_q;
            ti_d = imem_rdata;
            tp_d = inf_pc_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_fetch_ctrl;
  localparam int PW = 11;
  localparam logic [PW-1:0] STEP = 11'd4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_en;
  logic [PW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          redirect_valid = 1'b0;
  logic [PW-1:0] redirect_pc = '0;
  logic          halt_i = 1'b0;
  logic          if_valid;
  logic          if_ready = 1'b1;
  logic [31:0]   if_instr;
  logic [PW-1:0] if_pc;
  logic          halted_o;

  fetch_ctrl #(.PC_W(PW), .DATA_W(32), .RESET_PC(11'd0)) dut (
    .clk(clk), .rst(rst),
    .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_i(halt_i),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc),
    .halted_o(halted_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [PW-1:0] a);
    return {a[7:0] ^ 8'h5A, 5'd0, a, 8'hC3};
  endfunction

  // Synchronous instruction memory; garbage when not read.
  always @(posedge clk)
    imem_rdata <= imem_en ? memf(imem_addr) : 32'($urandom);

  typedef struct packed {
    logic [31:0]   ins;
    logic [PW-1:0] pc;
  } ent_t;

  ent_t          mq[$];
  bit            m_pv = 1'b0;
  logic [PW-1:0] m_pa = '0;
  logic [PW-1:0] m_pc = '0;
  int            m_mode = 0;
  int            total = 0;
  int            bad = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  // Drive one cycle, compare against the model, advance the model.
  task automatic cyc(input bit r, input bit rv, input logic [PW-1:0] rp,
                     input bit h, input bit rd);
    bit            ev, eis, pop;
    logic [PW-1:0] ea, tgt;
    ent_t          e;
    @(negedge clk);
    rst = r;
    redirect_valid = rv;
    redirect_pc = rp;
    halt_i = h;
    if_ready = rd;
    #1;
    if (r) begin
      chk("rst_en", imem_en, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_valid", if_valid, 0);
      chk("rst_instr", if_instr, 0);
      chk("rst_pc", if_pc, 0);
      chk("rst_halted", halted_o, 0);
      mq.delete();
      m_pv = 1'b0;
      m_pc = '0;
      m_mode = 0;
      return;
    end
    tgt = {rp[PW-1:2], 2'b00};
    ev  = (mq.size() > 0) && !rv;
    pop = ev && rd;
    if (rv) begin
      eis = (m_mode == 0) && !h;
      ea  = tgt;
    end else begin
      eis = (m_mode == 0) && !h &&
            (mq.size() + int'(m_pv) - int'(pop) < 2);
      ea  = m_pc;
    end
    chk("valid", if_valid, ev);
    chk("imem_en", imem_en, eis);
    if (eis) chk("imem_addr", imem_addr, ea);
    chk("halted", halted_o, m_mode == 2);
    if (ev) begin
      chk("if_pc", if_pc, mq[0].pc);
      chk("if_instr", if_instr, mq[0].ins);
    end
    if (rv) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_pv) begin
        e.ins = memf(m_pa);
        e.pc  = m_pa;
        mq.push_back(e);
      end
    end
    if (rv) m_pc = eis ? tgt + STEP : tgt;
    else if (eis) m_pc = m_pc + STEP;
    case (m_mode)
      0: if (h) m_mode = 1;
      1: if (!h) m_mode = 0; else if (!m_pv) m_mode = 2;
      2: if (!h) m_mode = 0;
      default: m_mode = 0;
    endcase
    m_pv = eis;
    m_pa = ea;
  endtask

  initial begin
    bit h;
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    // first fetch and in-order stream
    cyc(0, 0, 0, 0, 1);
    chk("t1_first_en", imem_en, 1);
    chk("t1_first_addr", imem_addr, 0);
    chk("t1_valid_n", if_valid, 0);
    cyc(0, 0, 0, 0, 1);
    chk("t1_valid_n1", if_valid, 0);
    cyc(0, 0, 0, 0, 1);
    chk("t1_valid_n2", if_valid, 1);
    chk("t1_pc0", if_pc, 'h000);
    cyc(0, 0, 0, 0, 1);
    chk("t1_pc1", if_pc, 'h004);
    cyc(0, 0, 0, 0, 1);
    chk("t1_pc2", if_pc, 'h008);
    // back-pressure
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("t2_frozen_pc", if_pc, 'h00C);
      chk("t2_no_issue", imem_en, 0);
    end
    cyc(0, 0, 0, 0, 1);
    chk("t2_rel0", if_pc, 'h00C);
    cyc(0, 0, 0, 0, 1);
    chk("t2_rel1", if_pc, 'h010);
    cyc(0, 0, 0, 0, 1);
    chk("t2_rel2", if_pc, 'h014);
    // redirect with work queued and in flight
    cyc(0, 1, 11'h123, 0, 0);
    chk("t3_en", imem_en, 1);
    chk("t3_addr", imem_addr, 'h120);
    chk("t3_valid_forced", if_valid, 0);
    cyc(0, 0, 0, 0, 1);
    chk("t3_gap", if_valid, 0);
    cyc(0, 0, 0, 0, 1);
    chk("t3_pc0", if_pc, 'h120);
    cyc(0, 0, 0, 0, 1);
    chk("t3_pc1", if_pc, 'h124);
    // wrap at the top of the address space
    cyc(0, 1, 11'h7F8, 0, 1);
    chk("t4_addr", imem_addr, 'h7F8);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t4_pc0", if_pc, 'h7F8);
    cyc(0, 0, 0, 0, 1);
    chk("t4_pc1", if_pc, 'h7FC);
    cyc(0, 0, 0, 0, 1);
    chk("t4_pc2", if_pc, 'h000);
    // halt, drain, redirect while halted, resume
    cyc(0, 0, 0, 1, 0);
    chk("t5_no_issue", imem_en, 0);
    cyc(0, 0, 0, 1, 0);
    chk("t5_drain", halted_o, 0);
    cyc(0, 0, 0, 1, 0);
    chk("t5_halted", halted_o, 1);
    chk("t5_q_valid", if_valid, 1);
    chk("t5_q_pc0", if_pc, 'h004);
    cyc(0, 0, 0, 1, 1);
    chk("t5_d0", if_pc, 'h004);
    cyc(0, 0, 0, 1, 1);
    chk("t5_d1", if_pc, 'h008);
    chk("t5_d1_en", imem_en, 0);
    cyc(0, 0, 0, 1, 1);
    chk("t5_empty", if_valid, 0);
    cyc(0, 1, 11'h040, 1, 1);
    chk("t5_redir_en", imem_en, 0);
    cyc(0, 0, 0, 0, 1);
    chk("t5_still_halt", halted_o, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t5_resume_en", imem_en, 1);
    chk("t5_resume_addr", imem_addr, 'h040);
    // reset mid-stream
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
    chk("t6_pre_valid", if_valid, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t6_valid0", if_valid, 0);
    chk("t6_addr", imem_addr, 0);
    cyc(0, 0, 0, 0, 1);
    chk("t6_valid1", if_valid, 0);
    cyc(0, 0, 0, 0, 1);
    chk("t6_pc", if_pc, 'h000);
    // random traffic
    h = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) h = !h;
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 11) == 0,
          11'($urandom), h, $urandom_range(0, 9) < 7);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch sequencer for the RV32I front end. It owns the PC, issues reads to the synchronous instruction memory, and buffers returned words in a 2-entry queue toward decode. It supports decode back-pressure, branch/jump redirect with in-flight squash, and halt/resume. It sits between the instruction memory and the decode stage.

Parameters:
PC_W, 11, byte-address width of PC and instruction memory.
DATA_W, 32, instruction width.
RESET_PC, 0, PC loaded on reset. Must be 4-byte aligned.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
imem_en  out  1  read strobe; data returns on imem_rdata exactly 1 cycle later
imem_addr  out  PC_W  read byte address, bits [1:0] always 0
imem_rdata  in  DATA_W  read data, valid the cycle after imem_en
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  PC_W  target; bits [1:0] ignored (treated as 0)
halt_i  in  1  level; stop issuing new fetches while high
if_valid  out  1  if_instr/if_pc hold a valid instruction
if_ready  in  1  decode accepts; transfer when if_valid && if_ready
if_instr  out  DATA_W  instruction at queue head
if_pc  out  PC_W  address of if_instr
halted_o  out  1  high in HALT state

Behaviour:
- Reset (rst high at edge): pc_next=RESET_PC; queue empty; in-flight cleared; state=RUN. All outputs are 0 during and after reset until the first issue: imem_en=0, if_valid=0, if_instr=0, if_pc=0, halted_o=0.
- States:
  - RUN: issue allowed. halt_i=1 -> DRAIN.
  - DRAIN: no issue. When in-flight=0 and halt_i=1 -> HALT. halt_i=0 -> RUN.
  - HALT: no issue; halted_o=1. halt_i=0 -> RUN.
- The queue keeps delivering in all states. Halt does not flush it.
- Issue condition (RUN only): occ + inflight - pop < 2, where pop = if_valid && if_ready.
  - On issue: imem_en=1, imem_addr=pc_next, pc_next += 4.
  - pc_next wraps modulo 2^PC_W (0x7FC -> 0x000 at PC_W=11).
- Response capture: the cycle after an issue, {imem_rdata, issued addr} is written to the queue tail. The entry becomes visible at the head the following cycle. There is no bypass.
- Latency: first issue at cycle N gives if_valid at N+2. With if_ready held high, throughput is 1 instr/cycle and PCs are consecutive.
- Back-pressure:
  - if_ready=0 holds if_instr/if_pc stable while if_valid=1.
  - The queue never exceeds 2 entries. Issue stalls so that no response is ever dropped.
- Queue is FIFO: simultaneous push and pop is legal at any occupancy, and occupancy is unchanged.
- Redirect (redirect_valid=1 in cycle N, any state):
  - Queue cleared at the end of N. if_valid is forced 0 combinationally in N, and no pop occurs.
  - Any response arriving in N+1 from an issue made before N is discarded, using a one-bit epoch.
  - In RUN: imem_en=1 and imem_addr={redirect_pc[PC_W-1:2],2'b00} in N; pc_next = that target + 4.
  - In DRAIN/HALT: no issue; pc_next = target. Fetch resumes from the target when the block returns to RUN.
  - Redirect dominates halt_i in the same cycle for PC update. The state transition still follows halt_i.
  - Back-to-back redirects: the last one wins. Each squashes the previous target's response.
- Reset mid-operation: in-flight response and queue contents are discarded. imem_rdata in the cycle after reset is ignored.

Test Plan:
1. Reset, RESET_PC=0, if_ready=1, imem returns addr-derived data -> if_valid rises 2 cycles after the first imem_en. if_pc sequence is 0x000, 0x004, 0x008, … with one instruction per cycle.
2. if_ready=0 for 5 cycles mid-stream -> if_instr/if_pc frozen. Occupancy reaches 2 and imem_en stays 0. On release there are no gaps, duplicates or losses.
3. redirect_valid with redirect_pc=0x123 while 2 entries are queued and one fetch is in flight:
   - imem_addr=0x120 in the same cycle; the squashed response is never presented.
   - Next delivered if_pc=0x120, then 0x124.
4. Start at pc_next=0x7F8 -> delivered if_pc sequence is 0x7F8, 0x7FC, 0x000.
5. halt_i=1 with one fetch in flight -> DRAIN for 1 cycle, then halted_o=1 and the queued entries still drain. redirect_pc=0x040 during HALT, then halt_i=0 -> first issue is at 0x040.
6. rst asserted for 1 cycle mid-stream with if_valid=1 -> if_valid=0 next cycle. The next delivered if_pc is RESET_PC, and no pre-reset data appears.
